pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Receives the pixel write stream (pixel_x, pixel_y, color) produced by the graphics Control block.
- Range-checks each pixel and converts its coordinates to a linear framebuffer address.
- Buffers accepted writes in a small FIFO and drains them to the framebuffer SRAM port over a req/ack handshake.
- Decouples Control's drawing rate from memory stalls.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- ADDR_W, 19, framebuffer address width (H_RES*V_RES-1 must fit).
- FIFO_DEPTH, 8, buffered entries; power of two.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel_x/pixel_y/color valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- pixel_x  in  16  column.
- pixel_y  in  16  row.
- color  in  24  RGB 8:8:8.
- mem_req  out  1  framebuffer write request.
- mem_addr  out  ADDR_W  linear address.
- mem_data  out  24  write data.
- mem_ack  in  1  write accepted by memory.
- dropped  out  16  count of discarded out-of-range pixels.
- busy  out  1  FIFO non-empty or mem_req high.

Behaviour:
- Reset (rst high at an edge):
  - FIFO emptied; mem_req=0, mem_addr=0, mem_data=0, dropped=0, busy=0.
  - pix_ready=0 while rst is high; pix_ready=1 in the first cycle after release.
- Accept:
  - Transfer occurs at an edge where pix_valid && pix_ready.
  - pix_ready = !rst && (fifo_count < FIFO_DEPTH), from registered count only. A pop in the same cycle does not make a full FIFO ready.
- Range check at accept:
  - In range: pixel_x < H_RES and pixel_y < V_RES. Push {addr = pixel_y*H_RES + pixel_x, truncated to ADDR_W; color}.
  - Otherwise: pixel is accepted but not pushed, and dropped increments, saturating at 16'hFFFF.
- Drain FSM, 2 states:
  - IDLE: mem_req=0. If FIFO non-empty: pop head into mem_addr/mem_data, set mem_req=1, go to REQ.
  - REQ: mem_req, mem_addr and mem_data are held stable until an edge with mem_ack=1.
    - On ack with FIFO non-empty: load the next head, pop, stay in REQ (mem_req stays 1). One write per cycle when ack is tied high.
    - On ack with FIFO empty: mem_req=0, go to IDLE.
  - mem_ack is ignored in IDLE.
- Latency: a pixel accepted at edge t into an idle, empty block drives mem_req=1 after edge t+1.
- Ordering: writes reach memory in acceptance order; no reordering or merging of duplicate addresses.
- Simultaneous push and pop: both take effect; count unchanged.
- busy = (fifo_count != 0) || mem_req.
- Reset mid-operation: an in-flight request is abandoned (mem_req=0 after the edge), buffered entries are lost, and no write is issued afterwards.

Test Plan:
- Reset: rst=1 for 2 cycles during random traffic -> mem_req=0, dropped=0, busy=0, pix_ready=0 during reset; pix_ready=1 on the first cycle after release.
- Single write: mem_ack tied 1, push x=10, y=2, color=24'hFF0000 -> exactly one mem_req cycle, 2 cycles after accept, mem_addr=1290, mem_data=24'hFF0000.
- Bounds:
  - Push x=640,y=0 and x=0,y=480 -> no mem_req, dropped=2.
  - Push x=639,y=479 -> mem_addr=307199.
- Backpressure:
  - Hold mem_ack=0 and push 12 pixels with sequential colors 1..12. The first enters REQ and 8 fill the FIFO, so pix_ready=0 after 9 accepts; mem_req and mem_addr stay stable throughout.
  - Then set mem_ack=1 -> remaining pixels accepted; 12 writes in order with colors 1..12, back-to-back.
- Mid-op reset: mem_ack=0, 4 pixels pushed (1 in REQ, 3 in FIFO), assert rst -> mem_req=0 after the edge; with mem_ack=1 afterwards, no further writes; busy=0.
- Saturation: push 65537 out-of-range pixels -> dropped=16'hFFFF, held there.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel writer: range-checks the Control pixel stream, maps (x,y) to a linear
// framebuffer address and drains buffered writes to the SRAM port over req/ack.
module pixel_writer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [15:0]       pixel_x,
    input  logic [15:0]       pixel_y,
    input  logic [23:0]       color,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_data,
    input  logic              mem_ack,
    output logic [15:0]       dropped,
    output logic              busy
);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    localparam int               ENTRY_W = ADDR_W + 24;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;
    logic [15:0]        dropped_q;
    logic [15:0]        dropped_d;
    state_t             state_q;
    logic               mem_req_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [23:0]        mem_data_q;

    logic               accept;
    logic               in_range;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [ADDR_W-1:0]  lin_addr;
    logic [ENTRY_W-1:0] head;

    // Readiness depends only on the registered count, so a same-cycle pop
    // never opens a slot for a pixel arriving while the FIFO is full.
    assign pix_ready  = !rst && (count_q < DEPTH_C);
    assign accept     = pix_valid && pix_ready;
    assign in_range   = (pixel_x < 16'(H_RES)) && (pixel_y < 16'(V_RES));
    assign push       = accept && in_range;
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || mem_ack);

    // Modular ADDR_W-bit arithmetic gives the truncated linear address directly.
    assign lin_addr = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
    assign head     = fifo_mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        dropped_d = dropped_q;
        if (accept && !in_range && (dropped_q != '1)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {lin_addr, color};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dropped_q  <= '0;
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            count_q   <= count_d;
            dropped_q <= dropped_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        mem_addr_q <= head[ENTRY_W-1:24];
                        mem_data_q <= head[23:0];
                        mem_req_q  <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (pop) begin
                            mem_addr_q <= head[ENTRY_W-1:24];
                            mem_data_q <= head[23:0];
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign dropped  = dropped_q;
    assign busy     = !fifo_empty || mem_req_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed scenarios plus random traffic
// checked against an acceptance-order write queue and a saturating drop count.
module tb_pixel_writer;

    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int ADDR_W     = 19;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              pix_valid;
    logic              pix_ready;
    logic [15:0]       pixel_x;
    logic [15:0]       pixel_y;
    logic [23:0]       color;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_data;
    logic              mem_ack;
    logic [15:0]       dropped;
    logic              busy;

    always #5 clk = ~clk;

    pixel_writer #(
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .color    (color),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .dropped  (dropped),
        .busy     (busy)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } wr_t;

    // Reference model: every accepted in-range pixel becomes one write, in order.
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int unsigned obs_cyc[$];
    wr_t         mon_w;
    wr_t         acc_w;
    int unsigned cyc         = 0;
    int unsigned req_cycles  = 0;
    int unsigned n_acc       = 0;
    logic [15:0] exp_dropped = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            exp_q.delete();
            obs_q.delete();
            obs_cyc.delete();
            exp_dropped <= '0;
        end else begin
            if (mem_req) req_cycles <= req_cycles + 1;
            if (mem_req && mem_ack) begin
                mon_w.addr = mem_addr;
                mon_w.data = mem_data;
                obs_q.push_back(mon_w);
                obs_cyc.push_back(cyc);
            end
            if (pix_valid && pix_ready) begin
                n_acc <= n_acc + 1;
                if (int'(pixel_x) < H_RES && int'(pixel_y) < V_RES) begin
                    acc_w.addr = ADDR_W'(int'(pixel_y) * H_RES + int'(pixel_x));
                    acc_w.data = color;
                    exp_q.push_back(acc_w);
                end else if (exp_dropped != 16'hFFFF) begin
                    exp_dropped <= exp_dropped + 16'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic v, input int x, input int y, input logic [23:0] c);
        pix_valid = v;
        pixel_x   = 16'(x);
        pixel_y   = 16'(y);
        color     = c;
    endtask

    task automatic drive_random_pix();
        drive_pix(1'($urandom_range(0, 1)), $urandom_range(0, 700), $urandom_range(0, 520),
                  24'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_random_pix();
            mem_ack = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_random_pix();
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_cmp++;
            if (pix_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready cycle %0d: got %b want 0", i, pix_ready);
            end
            tick();
        end
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || dropped !== 16'd0 ||
            mem_addr !== '0 || mem_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b busy=%b dropped=%0d addr=%0d data=%h want all 0",
                     mem_req, busy, dropped, mem_addr, mem_data);
        end
        rst = 1'b0;
        drive_pix(1'b0, 0, 0, '0);
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", pix_ready);
        end
        tick();
    endtask

    task automatic test_single_write();
        int unsigned r0;
        int          b0;
        mem_ack = 1'b1;
        r0 = req_cycles;
        b0 = obs_q.size();
        drive_pix(1'b1, 10, 2, 24'hFF0000);
        tick();
        drive_pix(1'b0, 0, 0, '0);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_t: mem_req=%b want 0", mem_req);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 19'd1290 || mem_data !== 24'hFF0000) begin
            n_fail++;
            $display("FAIL single_req: req=%b addr=%0d data=%h want 1/1290/ff0000",
                     mem_req, mem_addr, mem_data);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: mem_req=%b want 0", mem_req);
        end
        repeat (4) tick();
        n_cmp++;
        if (req_cycles - r0 != 1 || obs_q.size() != b0 + 1 || exp_q.size() != b0 + 1) begin
            n_fail++;
            $display("FAIL single_count: req_cycles=%0d writes=%0d want 1/1",
                     req_cycles - r0, obs_q.size() - b0);
        end else begin
            n_cmp++;
            if (obs_q[b0] !== exp_q[b0]) begin
                n_fail++;
                $display("FAIL single_model: got %h want %h", obs_q[b0], exp_q[b0]);
            end
        end
    endtask

    task automatic test_bounds();
        int unsigned r0;
        int          b0;
        mem_ack = 1'b1;
        r0 = req_cycles;
        drive_pix(1'b1, 640, 0, 24'h123456);
        tick();
        drive_pix(1'b1, 0, 480, 24'h654321);
        tick();
        drive_pix(1'b0, 0, 0, '0);
        repeat (4) tick();
        n_cmp++;
        if (dropped !== 16'd2 || req_cycles != r0) begin
            n_fail++;
            $display("FAIL bounds_drop: dropped=%0d reqs=%0d want 2/0", dropped, req_cycles - r0);
        end
        n_cmp++;
        if (dropped !== exp_dropped) begin
            n_fail++;
            $display("FAIL bounds_model_drop: got %0d want %0d", dropped, exp_dropped);
        end
        b0 = obs_q.size();
        drive_pix(1'b1, 639, 479, 24'($urandom));
        tick();
        drive_pix(1'b0, 0, 0, '0);
        repeat (4) tick();
        n_cmp++;
        if (obs_q.size() != b0 + 1 || exp_q.size() != b0 + 1) begin
            n_fail++;
            $display("FAIL bounds_corner_count: writes=%0d want 1", obs_q.size() - b0);
        end else if (obs_q[b0].addr !== 19'd307199 || obs_q[b0] !== exp_q[b0]) begin
            n_fail++;
            $display("FAIL bounds_corner: got addr=%0d data=%h want addr=307199 data=%h",
                     obs_q[b0].addr, obs_q[b0].data, exp_q[b0].data);
        end
    endtask

    task automatic test_backpressure();
        int unsigned a0;
        int          b0;
        int          sent;
        int          bx[12];
        int          by[12];
        logic        stable;
        logic        have;
        logic        done;
        logic [ADDR_W-1:0] held_addr;
        logic [23:0]       held_data;
        for (int k = 0; k < 12; k++) begin
            bx[k] = $urandom_range(0, H_RES - 1);
            by[k] = $urandom_range(0, V_RES - 1);
        end
        mem_ack = 1'b0;
        a0 = n_acc;
        b0 = obs_q.size();
        sent = 0;
        stable = 1'b1;
        have = 1'b0;
        held_addr = '0;
        held_data = '0;
        for (int c = 0; c < 16; c++) begin
            drive_pix(1'b1, bx[sent], by[sent], 24'(sent + 1));
            @(negedge clk);
            if (mem_req) begin
                if (!have) begin
                    have = 1'b1;
                    held_addr = mem_addr;
                    held_data = mem_data;
                end else if (mem_addr !== held_addr || mem_data !== held_data) begin
                    stable = 1'b0;
                end
            end else if (have) begin
                stable = 1'b0;
            end
            if (pix_ready) sent++;
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (n_acc - a0 != 9 || pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: accepts=%0d ready=%b want 9/0", n_acc - a0, pix_ready);
        end
        n_cmp++;
        if (stable !== 1'b1 || have !== 1'b1 || held_data !== 24'd1 || obs_q.size() != b0) begin
            n_fail++;
            $display("FAIL bp_hold: stable=%b seen=%b data=%h writes=%0d want 1/1/000001/0",
                     stable, have, held_data, obs_q.size() - b0);
        end
        tick();
        mem_ack = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (sent < 12) drive_pix(1'b1, bx[sent], by[sent], 24'(sent + 1));
            else drive_pix(1'b0, 0, 0, '0);
            @(negedge clk);
            if (pix_valid && pix_ready) sent++;
            tick();
            if (sent == 12 && busy === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done || obs_q.size() != b0 + 12 || exp_q.size() != b0 + 12) begin
            n_fail++;
            $display("FAIL bp_drain: done=%b writes=%0d want 1/12", done, obs_q.size() - b0);
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_cmp++;
                if (obs_q[b0+k].data !== 24'(k + 1) || obs_q[b0+k] !== exp_q[b0+k]) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h want %h", k, obs_q[b0+k], exp_q[b0+k]);
                end
            end
            for (int k = 0; k < 11; k++) begin
                n_cmp++;
                if (obs_cyc[b0+k+1] != obs_cyc[b0+k] + 1) begin
                    n_fail++;
                    $display("FAIL bp_b2b[%0d]: gap=%0d want 1", k,
                             obs_cyc[b0+k+1] - obs_cyc[b0+k]);
                end
            end
        end
    endtask

    task automatic test_midop_reset();
        int unsigned r0;
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_pix(1'b1, $urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
                      24'($urandom));
            tick();
        end
        drive_pix(1'b0, 0, 0, '0);
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_pre: req=%b busy=%b want 1/1", mem_req, busy);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_abandon: req=%b busy=%b want 0/0", mem_req, busy);
        end
        rst = 1'b0;
        mem_ack = 1'b1;
        r0 = req_cycles;
        repeat (10) tick();
        n_cmp++;
        if (obs_q.size() != 0 || req_cycles != r0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_after: writes=%0d reqs=%0d busy=%b want 0/0/0",
                     obs_q.size(), req_cycles - r0, busy);
        end
    endtask

    task automatic test_random();
        int   bad;
        int   first_bad;
        logic done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            pix_valid = ($urandom_range(0, 3) != 0);
            pixel_x = ($urandom_range(0, 9) < 9) ? 16'($urandom_range(0, H_RES - 1))
                                                  : 16'($urandom_range(H_RES, 65535));
            pixel_y = ($urandom_range(0, 9) < 9) ? 16'($urandom_range(0, V_RES - 1))
                                                  : 16'($urandom_range(V_RES, 65535));
            color = 24'($urandom);
            mem_ack = 1'($urandom_range(0, 1));
            tick();
        end
        drive_pix(1'b0, 0, 0, '0);
        mem_ack = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            tick();
            if (busy === 1'b0) done = 1'b1;
        end
        n_cmp++;
        if (!done || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: drained=%b writes=%0d want 1/%0d", done, obs_q.size(),
                     exp_q.size());
        end else begin
            bad = 0;
            first_bad = -1;
            for (int k = 0; k < obs_q.size(); k++) begin
                if (obs_q[k] !== exp_q[k]) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            n_cmp++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL rand_data: %0d bad entries, first #%0d got %h want %h", bad,
                         first_bad, obs_q[first_bad], exp_q[first_bad]);
            end
        end
        n_cmp++;
        if (dropped !== exp_dropped) begin
            n_fail++;
            $display("FAIL rand_dropped: got %0d want %0d", dropped, exp_dropped);
        end
    endtask

    task automatic test_saturation();
        int unsigned a0;
        int unsigned r0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        a0 = n_acc;
        r0 = req_cycles;
        for (int i = 0; i < 65534; i++) begin
            drive_pix(1'b1, H_RES + (i % 1000), $urandom_range(0, 65535), 24'(i));
            tick();
        end
        n_cmp++;
        if (dropped !== 16'hFFFE || n_acc - a0 != 65534) begin
            n_fail++;
            $display("FAIL sat_pre: dropped=%h accepts=%0d want fffe/65534", dropped, n_acc - a0);
        end
        tick();
        n_cmp++;
        if (dropped !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: got %h want ffff", dropped);
        end
        repeat (2) tick();
        drive_pix(1'b0, 0, 0, '0);
        n_cmp++;
        if (dropped !== 16'hFFFF || dropped !== exp_dropped || req_cycles != r0) begin
            n_fail++;
            $display("FAIL sat_hold: got %h model %h reqs=%0d want ffff/ffff/0", dropped,
                     exp_dropped, req_cycles - r0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_ack = 1'b0;
        drive_pix(1'b0, 0, 0, '0);
        repeat (2) tick();
        test_reset();
        test_single_write();
        test_bounds();
        test_backpressure();
        test_midop_reset();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
